// File: rtl/i2c_poll_sequencer_if.sv
// Command/response port between the polling sequencer and the low-level
// I2C byte engine. The sequencer is the master (issues commands), the
// engine is the slave (returns done/nack/read data).
interface i2c_poll_sequencer_if #(
   parameter int MAX_BYTES = 6
);
   localparam int NB_W = $clog2(MAX_BYTES + 1);

   logic                   ll_start;
   logic                   ll_abort;
   logic                   ll_write;
   logic [6:0]             ll_dev_addr;
   logic [7:0]             ll_reg_addr;
   logic [NB_W-1:0]        ll_num_bytes;
   logic [7:0]             ll_wdata;
   logic                   ll_done;
   logic                   ll_nack;
   logic [8*MAX_BYTES-1:0] ll_rdata;

   modport master (
      output ll_start, ll_abort, ll_write, ll_dev_addr, ll_reg_addr,
             ll_num_bytes, ll_wdata,
      input  ll_done, ll_nack, ll_rdata
   );

   modport slave (
      input  ll_start, ll_abort, ll_write, ll_dev_addr, ll_reg_addr,
             ll_num_bytes, ll_wdata,
      output ll_done, ll_nack, ll_rdata
   );
endinterface

// File: rtl/i2c_poll_sequencer.sv
// Multi-channel I2C polling sequencer. On each poll round it visits every
// channel in order: a two-write init handshake for channels not yet online,
// then a register-pointer write and a burst read. NACKed or timed-out
// commands are retried; after MAX_RETRY attempts the channel goes offline.
// Optional feature macro: I2C_POLL_ZERO_FILTER_EN -- when defined, a good
// read whose first three bytes are all zero is silently discarded.
module i2c_poll_sequencer #(
   parameter int                NUM_CH      = 2,
   parameter int                MAX_BYTES   = 6,
   parameter int                READ_BYTES  = 6,
   parameter logic [7*NUM_CH-1:0] DEV_ADDRS = {7'h52, 7'h52},
   parameter logic [7:0]        INIT1_REG   = 8'hF0,
   parameter logic [7:0]        INIT1_DATA  = 8'h55,
   parameter logic [7:0]        INIT2_REG   = 8'hFB,
   parameter logic [7:0]        INIT2_DATA  = 8'h00,
   parameter int                MAX_RETRY   = 3,
   parameter int                TIMEOUT_CYC = 4096
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          poll_tick,
   i2c_poll_sequencer_if.master          bus,
   output logic [NUM_CH*8*READ_BYTES-1:0] ch_data,
   output logic [NUM_CH-1:0]             ch_valid,
   output logic [NUM_CH-1:0]             ch_online,
   output logic [7:0]                    err_count,
   output logic                          busy
);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NB_W   = $clog2(MAX_BYTES + 1);
   localparam int RT_W   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam int SLOT_W = 8 * READ_BYTES;
   localparam int ADDR_W = 7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT1 = 3'd1,
      S_INIT2 = 3'd2,
      S_PTR   = 3'd3,
      S_READ  = 3'd4,
      S_NEXT  = 3'd5
   } state_t;

   state_t                     r_state;
   logic [CH_W-1:0]            r_ch;
   logic                       r_busy;
   logic                       r_pending;
   logic                       r_issue;        // launch a command next cycle
   logic                       r_outstanding;  // command in flight at engine
   logic [RT_W-1:0]            r_retry;
   logic [TO_W-1:0]            r_timer;
   logic                       r_ll_start;
   logic                       r_ll_abort;
   logic                       r_ll_write;
   logic [6:0]                 r_ll_dev_addr;
   logic [7:0]                 r_ll_reg_addr;
   logic [NB_W-1:0]            r_ll_num_bytes;
   logic [7:0]                 r_ll_wdata;
   logic [NUM_CH*SLOT_W-1:0]   r_ch_data;
   logic [NUM_CH-1:0]          r_ch_valid;
   logic [NUM_CH-1:0]          r_ch_online;
   logic [7:0]                 r_err_count;

   logic                       w_ch_last;
   logic [CH_W-1:0]            w_ch_inc;
   logic                       w_done_ok;
   logic                       w_fail_nack;
   logic                       w_timeout;
   logic                       w_fail;
   logic                       w_retry_exhausted;
   logic                       w_tick_start;
   logic                       w_discard;
   logic [SLOT_W-1:0]          w_rd_slot;
   logic [6:0]                 w_dev_addr;

   assign w_ch_last         = (r_ch == CH_W'(NUM_CH - 1));
   assign w_ch_inc          = r_ch + CH_W'(1);
   assign w_done_ok         = r_outstanding && bus.ll_done && !bus.ll_nack;
   assign w_fail_nack       = r_outstanding && bus.ll_done && bus.ll_nack;
   // A done arriving on the expiry cycle takes precedence over the timeout.
   assign w_timeout         = r_outstanding && !bus.ll_done &&
                              (r_timer == TO_W'(TIMEOUT_CYC - 1));
   assign w_fail            = w_fail_nack || w_timeout;
   assign w_retry_exhausted = (r_retry == RT_W'(MAX_RETRY - 1));
   assign w_tick_start      = poll_tick || r_pending;
   assign w_rd_slot         = bus.ll_rdata[SLOT_W-1:0];
   assign w_dev_addr        = DEV_ADDRS[r_ch*ADDR_W +: ADDR_W];

`ifdef I2C_POLL_ZERO_FILTER_EN
   // All-zero leading bytes mean the peripheral returned an empty frame.
   assign w_discard = (bus.ll_rdata[23:0] == 24'h00_0000);
`else
   assign w_discard = 1'b0;
`endif

   // Polling FSM: command issue, retry/timeout handling, channel bookkeeping.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_ch           <= '0;
         r_busy         <= 1'b0;
         r_pending      <= 1'b0;
         r_issue        <= 1'b0;
         r_outstanding  <= 1'b0;
         r_retry        <= '0;
         r_timer        <= '0;
         r_ll_start     <= 1'b0;
         r_ll_abort     <= 1'b0;
         r_ll_write     <= 1'b0;
         r_ll_dev_addr  <= 7'h00;
         r_ll_reg_addr  <= 8'h00;
         r_ll_num_bytes <= '0;
         r_ll_wdata     <= 8'h00;
         r_ch_data      <= '0;
         r_ch_valid     <= '0;
         r_ch_online    <= '0;
         r_err_count    <= 8'h00;
      end else begin
         r_ll_start <= 1'b0;
         r_ll_abort <= 1'b0;
         r_ch_valid <= '0;

         // Busy is high everywhere outside IDLE, so this also catches a tick
         // on the very cycle the FSM returns to IDLE.
         if (poll_tick && r_busy) begin
            r_pending <= 1'b1;
         end

         if (r_outstanding) begin
            r_timer <= r_timer + TO_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (w_tick_start) begin
                  r_pending <= 1'b0;
                  r_busy    <= 1'b1;
                  r_ch      <= '0;
                  r_retry   <= '0;
                  r_issue   <= 1'b1;
                  r_state   <= r_ch_online[0] ? S_PTR : S_INIT1;
               end
            end

            S_INIT1, S_INIT2, S_PTR, S_READ: begin
               if (r_issue) begin
                  r_issue       <= 1'b0;
                  r_ll_start    <= 1'b1;
                  r_outstanding <= 1'b1;
                  r_timer       <= '0;
                  r_ll_dev_addr <= w_dev_addr;
                  case (r_state)
                     S_INIT1: begin
                        r_ll_write     <= 1'b1;
                        r_ll_reg_addr  <= INIT1_REG;
                        r_ll_num_bytes <= NB_W'(1);
                        r_ll_wdata     <= INIT1_DATA;
                     end
                     S_INIT2: begin
                        r_ll_write     <= 1'b1;
                        r_ll_reg_addr  <= INIT2_REG;
                        r_ll_num_bytes <= NB_W'(1);
                        r_ll_wdata     <= INIT2_DATA;
                     end
                     S_PTR: begin
                        r_ll_write     <= 1'b1;
                        r_ll_reg_addr  <= 8'h00;
                        r_ll_num_bytes <= NB_W'(0);
                        r_ll_wdata     <= 8'h00;
                     end
                     default: begin
                        r_ll_write     <= 1'b0;
                        r_ll_reg_addr  <= 8'h00;
                        r_ll_num_bytes <= NB_W'(READ_BYTES);
                        r_ll_wdata     <= 8'h00;
                     end
                  endcase
               end else if (w_done_ok) begin
                  r_outstanding <= 1'b0;
                  r_retry       <= '0;
                  case (r_state)
                     S_INIT1: begin
                        r_state <= S_INIT2;
                        r_issue <= 1'b1;
                     end
                     S_INIT2: begin
                        r_ch_online[r_ch] <= 1'b1;
                        r_state           <= S_PTR;
                        r_issue           <= 1'b1;
                     end
                     S_PTR: begin
                        r_state <= S_READ;
                        r_issue <= 1'b1;
                     end
                     default: begin
                        if (!w_discard) begin
                           r_ch_data[r_ch*SLOT_W +: SLOT_W] <= w_rd_slot;
                           r_ch_valid[r_ch]                 <= 1'b1;
                        end
                        r_state <= S_NEXT;
                     end
                  endcase
               end else if (w_fail) begin
                  r_outstanding <= 1'b0;
                  r_ll_abort    <= w_timeout;
                  if (w_retry_exhausted) begin
                     r_ch_online[r_ch] <= 1'b0;
                     if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                     end
                     r_retry <= '0;
                     r_state <= S_NEXT;
                  end else begin
                     r_retry <= r_retry + RT_W'(1);
                     r_issue <= 1'b1;
                  end
               end
            end

            S_NEXT: begin
               if (w_ch_last) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_ch    <= w_ch_inc;
                  r_retry <= '0;
                  r_issue <= 1'b1;
                  r_state <= r_ch_online[w_ch_inc] ? S_PTR : S_INIT1;
               end
            end

            default: begin
               r_busy        <= 1'b0;
               r_issue       <= 1'b0;
               r_outstanding <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ll_start     = r_ll_start;
   assign bus.ll_abort     = r_ll_abort;
   assign bus.ll_write     = r_ll_write;
   assign bus.ll_dev_addr  = r_ll_dev_addr;
   assign bus.ll_reg_addr  = r_ll_reg_addr;
   assign bus.ll_num_bytes = r_ll_num_bytes;
   assign bus.ll_wdata     = r_ll_wdata;
   assign ch_data          = r_ch_data;
   assign ch_valid         = r_ch_valid;
   assign ch_online        = r_ch_online;
   assign err_count        = r_err_count;
   assign busy             = r_busy;
endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Testbench for i2c_poll_sequencer: a small engine model answers commands
// (ACK, NACK on ch1 reads, silence on ch1, or a zero-led data pattern).
// Round-level results come from a vector table; timing corners are
// exercised by hand-written sequences.
module tb_i2c_poll_sequencer;
   localparam int MAX_BYTES = 6;
   localparam int TIMEOUT   = 16;
   localparam logic [95:0] D_ACK  = {48'h25_24_23_22_21_20, 48'h15_14_13_12_11_10};
   localparam logic [95:0] D_ZERO = {48'h33_22_11_00_00_00, 48'h33_22_11_00_00_00};

   logic        clock = 1'b0;
   logic        rst;
   logic        poll_tick;
   logic [95:0] ch_data;
   logic [1:0]  ch_valid;
   logic [1:0]  ch_online;
   logic [7:0]  err_count;
   logic        busy;

   always #5 clock = ~clock;

   i2c_poll_sequencer_if #(.MAX_BYTES(MAX_BYTES)) bus ();

   i2c_poll_sequencer #(
      .NUM_CH(2), .MAX_BYTES(MAX_BYTES), .READ_BYTES(6),
      .DEV_ADDRS({7'h53, 7'h52}), .MAX_RETRY(3), .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clock(clock), .rst(rst), .poll_tick(poll_tick), .bus(bus),
      .ch_data(ch_data), .ch_valid(ch_valid), .ch_online(ch_online),
      .err_count(err_count), .busy(busy)
   );

   // ---------------- engine model ----------------
   int          mode = 0;   // 0 ACK, 1 NACK ch1 reads, 2 ch1 silent, 3 zero data
   int          cyc = 0;
   int          last_start = 0;
   logic        m_busy;
   int          m_cnt;
   logic [6:0]  m_dev;
   logic        m_wr;
   logic [31:0] cmd_log[$];
   int          abort_gap[$];
   int          n_v0 = 0, n_v1 = 0;

   // Free-running cycle counter for timing measurements.
   always @(posedge clock) cyc <= cyc + 1;

   // Engine model: logs commands, answers three cycles after accepting one.
   always @(posedge clock or posedge rst) begin
      if (rst) begin
         bus.ll_done  <= 1'b0;
         bus.ll_nack  <= 1'b0;
         bus.ll_rdata <= '0;
         m_busy       <= 1'b0;
         m_cnt        <= 0;
      end else begin
         bus.ll_done <= 1'b0;
         bus.ll_nack <= 1'b0;
         if (bus.ll_abort) begin
            m_busy <= 1'b0;
            abort_gap.push_back(cyc - last_start);
         end else if (bus.ll_start) begin
            m_busy     <= 1'b1;
            m_cnt      <= 0;
            m_dev      <= bus.ll_dev_addr;
            m_wr       <= bus.ll_write;
            last_start <= cyc;
            cmd_log.push_back({3'b000, bus.ll_write, bus.ll_dev_addr, bus.ll_reg_addr,
                               5'(bus.ll_num_bytes), bus.ll_wdata});
         end else if (m_busy && !(mode == 2 && m_dev == 7'h53)) begin
            if (m_cnt == 2) begin
               m_busy      <= 1'b0;
               bus.ll_done <= 1'b1;
               if (mode == 1 && m_dev == 7'h53 && !m_wr) begin
                  bus.ll_nack  <= 1'b1;
                  bus.ll_rdata <= 48'hEE_EE_EE_EE_EE_EE;
               end else if (mode == 3) begin
                  bus.ll_rdata <= 48'h33_22_11_00_00_00;
               end else begin
                  bus.ll_rdata <= (m_dev == 7'h53) ? 48'h25_24_23_22_21_20
                                                   : 48'h15_14_13_12_11_10;
               end
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   // Count ch_valid pulses per channel.
   always @(posedge clock) begin
      if (!rst) begin
         if (ch_valid[0]) n_v0 <= n_v0 + 1;
         if (ch_valid[1]) n_v1 <= n_v1 + 1;
      end
   end

   // ---------------- checking helpers ----------------
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected command word: 0 INIT1, 1 INIT2, 2 PTR, 3 READ.
   function automatic logic [31:0] cmd_exp(input int kind, input logic [6:0] dev);
      case (kind)
         0:       cmd_exp = {3'b000, 1'b1, dev, 8'hF0, 5'd1, 8'h55};
         1:       cmd_exp = {3'b000, 1'b1, dev, 8'hFB, 5'd1, 8'h00};
         2:       cmd_exp = {3'b000, 1'b1, dev, 8'h00, 5'd0, 8'h00};
         default: cmd_exp = {3'b000, 1'b0, dev, 8'h00, 5'd6, 8'h00};
      endcase
   endfunction

   // Fields that carry no meaning for a command are masked out.
   function automatic logic [31:0] cmd_mask(input int kind);
      case (kind)
         2:       cmd_mask = 32'hFFFF_FF00;
         3:       cmd_mask = 32'hFFE0_1F00;
         default: cmd_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic chk_cmd(input string name, input int idx, input int kind, input logic [6:0] dev);
      if (idx < cmd_log.size())
         chk(name, 96'(cmd_log[idx] & cmd_mask(kind)), 96'(cmd_exp(kind, dev) & cmd_mask(kind)));
      else
         chk({name, "_missing"}, 96'(cmd_log.size()), 96'(idx + 1));
   endtask

   task automatic pulse_tick();
      poll_tick = 1'b1;
      @(negedge clock);
      poll_tick = 1'b0;
   endtask

   task automatic wait_busy(input logic level, input int budget);
      int t = 0;
      while (busy !== level && t < budget) begin
         @(negedge clock);
         t++;
      end
   endtask

   typedef struct {
      int          mode;
      int          cmds;
      int          v0;
      int          v1;
      logic [1:0]  online;
      logic [7:0]  err;
      int          aborts;
      logic [95:0] data;
   } vec_t;

   vec_t vecs[6];
   int   start_idx[6];

   initial begin
      int c0, a0, p0, q0, t;

      vecs[0] = '{0, 8, 1, 1, 2'b11, 8'd0, 0, D_ACK};  // first round with inits
      vecs[1] = '{0, 4, 1, 1, 2'b11, 8'd0, 0, D_ACK};  // steady state, no inits
      vecs[2] = '{1, 6, 1, 0, 2'b01, 8'd1, 0, D_ACK};  // ch1 READ NACKed 3x
      vecs[3] = '{0, 6, 1, 1, 2'b11, 8'd1, 0, D_ACK};  // ch1 re-inits
      vecs[4] = '{2, 5, 1, 0, 2'b01, 8'd2, 3, D_ACK};  // ch1 PTR times out 3x
`ifdef I2C_POLL_ZERO_FILTER_EN
      vecs[5] = '{3, 6, 0, 0, 2'b11, 8'd2, 0, D_ACK};
`else
      vecs[5] = '{3, 6, 1, 1, 2'b11, 8'd2, 0, D_ZERO};
`endif

      rst = 1'b1;
      poll_tick = 1'b0;
      repeat (3) @(negedge clock);
      rst = 1'b0;
      @(negedge clock);
      chk("reset_busy", 96'(busy), 96'(0));
      chk("reset_online", 96'(ch_online), 96'(0));
      chk("reset_err", 96'(err_count), 96'(0));
      chk("reset_data", ch_data, 96'(0));
      chk("reset_ll_start", 96'(bus.ll_start), 96'(0));

      // ---------- table-driven rounds ----------
      for (int i = 0; i < 6; i++) begin
         mode = vecs[i].mode;
         c0 = cmd_log.size(); a0 = abort_gap.size(); p0 = n_v0; q0 = n_v1;
         start_idx[i] = c0;
         pulse_tick();
         chk($sformatf("v%0d_busy_rise", i), 96'(busy), 96'(1));
         wait_busy(1'b0, 3000);
         chk($sformatf("v%0d_round_end", i), 96'(busy), 96'(0));
         chk($sformatf("v%0d_cmds", i), 96'(cmd_log.size() - c0), 96'(vecs[i].cmds));
         chk($sformatf("v%0d_valid0", i), 96'(n_v0 - p0), 96'(vecs[i].v0));
         chk($sformatf("v%0d_valid1", i), 96'(n_v1 - q0), 96'(vecs[i].v1));
         chk($sformatf("v%0d_online", i), 96'(ch_online), 96'(vecs[i].online));
         chk($sformatf("v%0d_err", i), 96'(err_count), 96'(vecs[i].err));
         chk($sformatf("v%0d_aborts", i), 96'(abort_gap.size() - a0), 96'(vecs[i].aborts));
         chk($sformatf("v%0d_data", i), ch_data, vecs[i].data);
         repeat (3) @(negedge clock);
      end

      // ---------- command order of first two rounds ----------
      for (int k = 0; k < 4; k++) begin
         chk_cmd($sformatf("r0_ch0_cmd%0d", k), start_idx[0] + k, k, 7'h52);
         chk_cmd($sformatf("r0_ch1_cmd%0d", k), start_idx[0] + 4 + k, k, 7'h53);
      end
      chk_cmd("r1_ch0_ptr", start_idx[1] + 0, 2, 7'h52);
      chk_cmd("r1_ch0_read", start_idx[1] + 1, 3, 7'h52);
      chk_cmd("r1_ch1_ptr", start_idx[1] + 2, 2, 7'h53);
      chk_cmd("r1_ch1_read", start_idx[1] + 3, 3, 7'h53);
      chk_cmd("r2_ch1_read_retry", start_idx[2] + 5, 3, 7'h53);
      chk_cmd("r4_ch1_ptr_retry", start_idx[4] + 4, 2, 7'h53);

      // ---------- abort spacing after ll_start ----------
      foreach (abort_gap[j]) chk($sformatf("abort_gap%0d", j), 96'(abort_gap[j]), 96'(TIMEOUT));

      // ---------- three ticks in one round -> one extra round ----------
      mode = 0;
      c0 = cmd_log.size();
      pulse_tick();
      repeat (3) @(negedge clock);
      pulse_tick();
      repeat (2) @(negedge clock);
      pulse_tick();
      wait_busy(1'b0, 3000);
      chk("multi_first_end", 96'(busy), 96'(0));
      wait_busy(1'b1, 5);
      chk("multi_extra_start", 96'(busy), 96'(1));
      wait_busy(1'b0, 3000);
      repeat (200) @(negedge clock);
      chk("multi_no_third", 96'(busy), 96'(0));
      chk("multi_cmds", 96'(cmd_log.size() - c0), 96'(8));

      // ---------- tick on the cycle the FSM re-enters IDLE ----------
      c0 = cmd_log.size();
      pulse_tick();
      t = 0;
      while (ch_valid[1] !== 1'b1 && t < 3000) begin
         @(negedge clock);
         t++;
      end
      chk("edge_valid1_seen", 96'(ch_valid[1]), 96'(1));
      pulse_tick();
      chk("edge_idle_entered", 96'(busy), 96'(0));
      @(negedge clock);
      chk("edge_pending_round", 96'(busy), 96'(1));
      wait_busy(1'b0, 3000);
      chk("edge_cmds", 96'(cmd_log.size() - c0), 96'(8));

      // ---------- asynchronous reset in the middle of READ ----------
      pulse_tick();
      t = 0;
      while (!(bus.ll_start === 1'b1 && bus.ll_write === 1'b0) && t < 3000) begin
         @(negedge clock);
         t++;
      end
      chk("rst_read_seen", 96'(bus.ll_write), 96'(0));
      @(negedge clock);
      #2 rst = 1'b1;
      #1;
      chk("rst_online", 96'(ch_online), 96'(0));
      chk("rst_data", ch_data, 96'(0));
      chk("rst_err", 96'(err_count), 96'(0));
      chk("rst_busy", 96'(busy), 96'(0));
      chk("rst_valid", 96'(ch_valid), 96'(0));
      chk("rst_cmd_fields", 96'({bus.ll_start, bus.ll_abort, bus.ll_write, bus.ll_dev_addr,
                                 bus.ll_reg_addr, bus.ll_num_bytes, bus.ll_wdata}), 96'(0));
      @(negedge clock);
      rst = 1'b0;
      @(negedge clock);
      c0 = cmd_log.size();
      pulse_tick();
      wait_busy(1'b0, 3000);
      chk("post_rst_cmds", 96'(cmd_log.size() - c0), 96'(8));
      chk("post_rst_online", 96'(ch_online), 96'(2'b11));
      chk("post_rst_data", ch_data, D_ACK);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_poll_sequencer.md
# i2c_poll_sequencer

Multi-channel, parametrised I2C polling sequencer: the successor to the single-nunchuck polling FSM. On each poll tick it walks through `NUM_CH` I2C peripherals in order. For each one it runs a two-write init handshake once, then a register-pointer write and a burst read. It drives the existing low-level I2C byte engine through a start/done command port, retries NACKed or timed-out transactions, and tracks each channel's online state. Translators (e.g. nunchuck decode) sit downstream on the per-channel data slots.

## Interface
Parameters:
- `NUM_CH`, 2: number of polled peripherals, 1..8.
- `MAX_BYTES`, 6: width of the low-level data bus in bytes.
- `READ_BYTES`, 6: bytes per burst read, 1..`MAX_BYTES`.
- `DEV_ADDRS`, {7'h52, 7'h52}: packed 7-bit address per channel, ch0 in the LSBs.
- `INIT1_REG`/`INIT1_DATA`, 8'hF0/8'h55: first handshake write.
- `INIT2_REG`/`INIT2_DATA`, 8'hFB/8'h00: second handshake write.
- `MAX_RETRY`, 3: attempts per transaction before the channel is declared offline.
- `TIMEOUT_CYC`, 4096: clock cycles allowed from `ll_start` to `ll_done`.

Ports:
- `clock`  in  1: I2C-domain clock; one clock only.
- `rst`  in  1: asynchronous, active-high reset.
- `poll_tick`  in  1: one-cycle pulse that starts a polling round.
- `ll_start`  out  1: one-cycle command strobe to the low-level engine.
- `ll_abort`  out  1: one-cycle strobe that cancels a timed-out command.
- `ll_write`  out  1: 1 = write command, 0 = read command.
- `ll_dev_addr`  out  7: 7-bit device address.
- `ll_reg_addr`  out  8: register address.
- `ll_num_bytes`  out  $clog2(MAX_BYTES+1): number of payload bytes.
- `ll_wdata`  out  8: write payload byte.
- `ll_done`  in  1: one-cycle completion pulse from the engine.
- `ll_nack`  in  1: valid only together with `ll_done`.
- `ll_rdata`  in  8*MAX_BYTES: read data, byte 0 in the LSBs.
- `ch_data`  out  NUM_CH*8*READ_BYTES: last good read for each channel.
- `ch_valid`  out  NUM_CH: one-cycle pulse when that channel's slot updates.
- `ch_online`  out  NUM_CH: 1 = channel is initialised and responding.
- `err_count`  out  8: saturating count of transactions abandoned after all retries.
- `busy`  out  1: high while a polling round is in progress.

## Operation
- FSM states: IDLE, INIT1, INIT2, PTR, READ, NEXT.
- IDLE: on `poll_tick` (or a pending tick), set ch=0, assert `busy`, and go to INIT1 if `ch_online[ch]`=0, otherwise to PTR.
- Per-state commands:
  - INIT1 writes 1 byte `INIT1_DATA` to `INIT1_REG`, then goes to INIT2.
  - INIT2 writes 1 byte `INIT2_DATA` to `INIT2_REG`, sets `ch_online[ch]`, then goes to PTR.
  - PTR is a write with 0 bytes to register 8'h00, then goes to READ.
  - READ is a read of `READ_BYTES` bytes, then goes to NEXT.
- READ success: copy `ll_rdata[8*READ_BYTES-1:0]` into slot ch and pulse `ch_valid[ch]`.
- Failure is `ll_done` with `ll_nack`=1, or a timeout:
  - Increment the retry counter and re-issue the same command.
  - When the counter reaches `MAX_RETRY`: clear `ch_online[ch]`, increment `err_count` (saturates at 255), leave the slot unchanged, and go to NEXT.
- Retry counter: cleared on every state entry.
- NEXT: if ch=`NUM_CH`-1, go to IDLE and drop `busy`; otherwise increment ch and pick INIT1 or PTR as in IDLE.
- `poll_tick` while `busy`: set a one-deep pending flag. Further ticks are dropped. The pending flag starts the next round immediately on return to IDLE.
- Command fields in IDLE/NEXT: hold previous values; they carry no meaning.

## Timing
- `ll_start` fires exactly one cycle after each state entry or retry decision. All `ll_*` command fields are registered and stable from `ll_start` until `ll_done`.
- Timeout counter:
  - Starts at `ll_start`.
  - If `TIMEOUT_CYC` cycles pass with no `ll_done`, pulse `ll_abort` for one cycle and treat it as a failure.
  - A `ll_done` arriving in the same cycle as the timeout wins; it counts as completion.
- Same-cycle events:
  - `ll_done` with no outstanding command is ignored.
  - `poll_tick` arriving in the same cycle the FSM enters IDLE becomes a pending tick, not a lost one.
- Latency: `ll_done` of READ to `ch_valid` is 1 cycle. `ch_data` updates in the same cycle as `ch_valid`.
- Reset (asynchronous, including mid-transaction):
  - state=IDLE, `busy`=0, pending=0, ch=0.
  - `ch_online`=0, `ch_valid`=0, `ch_data`=0, `err_count`=0.
  - `ll_start`=0, `ll_abort`=0, `ll_write`=0, `ll_num_bytes`=0, addresses=0, `ll_wdata`=0.
  - The engine must be reset by the same `rst`.

## Configuration
- `I2C_POLL_ZERO_FILTER_EN`:
  - Defined: a successful READ whose bytes 0..2 are all 8'h00 is discarded. The slot is unchanged, no `ch_valid` pulse, no retry, no `err_count` change, and the FSM moves on to NEXT.
  - Undefined: every successful read updates the slot.

## Test plan
- `NUM_CH`=2, `DEV_ADDRS`={52,53}, always-ACK model, one `poll_tick`:
  - Command sequence is INIT1, INIT2, PTR, READ for ch0, then the same for ch1.
  - `ch_online`=2'b11, two `ch_valid` pulses, `ch_data` equals the model bytes.
- Second `poll_tick` after the first round: only PTR and READ per channel, with no INIT commands.
- Model NACKs ch1 forever:
  - 3 READ attempts, then `ch_online[1]`=0 and `err_count`=1, with the ch1 slot unchanged.
  - The next round restarts ch1 at INIT1.
- Model never returns `ll_done`, `TIMEOUT_CYC`=16: `ll_abort` pulses 16 cycles after each `ll_start`, 3 times, then the sequencer advances to the next channel.
- Three `poll_tick`s during one round: exactly one extra round runs afterwards; `rst` asserted mid-READ gives all-zero outputs within the same cycle.
- `I2C_POLL_ZERO_FILTER_EN` defined, model returns 00 00 00 11 22 33: no `ch_valid` and the slot is unchanged; undefined, the slot becomes 33_22_11_00_00_00.
